rr_burst_scheduler: RTL and testbench

- Shares one downstream burst port among REQ_LINES requesters.
- Uses mask-based round-robin priority, so every requester gets a turn.
- Unlike a single-cycle arbiter, each grant is held for a whole multi-beat burst. The burst length is captured from the requester when the grant is issued.
- The next grant is issued on the last-beat cycle of the current burst, so back-to-back bursts run with no idle cycle. Sits between requester blocks and the shared bus or memory port.

---
 rtl/rr_burst_scheduler_if.sv | 27 ++
 rtl/rr_burst_scheduler.sv | 110 +++++++++++
 tb/tb_rr_burst_scheduler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/rr_burst_scheduler_if.sv
// Bundles the requester-side and downstream-burst signals of rr_burst_scheduler.
// The slave modport is the scheduler's view; master is the requester/downstream side.
interface rr_burst_scheduler_if #(
  parameter int REQ_LINES = 4,
  parameter int LEN_W     = 4
);
  localparam int ID_W = $clog2(REQ_LINES);

  logic [REQ_LINES-1:0]       req;
  logic [REQ_LINES*LEN_W-1:0] req_len;
  logic                       out_ready;
  logic [REQ_LINES-1:0]       gnt;
  logic [ID_W-1:0]            gnt_id;
  logic                       out_valid;
  logic                       out_last;
  logic                       busy;

  modport slave (
    input  req, req_len, out_ready,
    output gnt, gnt_id, out_valid, out_last, busy
  );

  modport master (
    output req, req_len, out_ready,
    input  gnt, gnt_id, out_valid, out_last, busy
  );
endinterface

// File: rtl/rr_burst_scheduler.sv
// Round-robin burst scheduler: each grant is held for a whole multi-beat burst and
// the next grant is loaded on the last beat, so back-to-back bursts have no bubble.
module rr_burst_scheduler #(
  parameter int REQ_LINES = 4,
  parameter int LEN_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_burst_scheduler_if.slave  bus
);
  localparam int ID_W = $clog2(REQ_LINES);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                r_state, w_state_nxt;
  logic [REQ_LINES-1:0]  r_ptr, w_ptr_nxt;
  logic [REQ_LINES-1:0]  r_gnt, w_gnt_nxt;
  logic [ID_W-1:0]       r_gnt_id, w_gnt_id_nxt;
  logic [LEN_W-1:0]      r_cnt, w_cnt_nxt;

  logic [REQ_LINES-1:0]  w_ptr_after, w_arb_ptr, w_masked;
  logic [ID_W-1:0]       w_win;
  logic                  w_xfer, w_last_beat;

  function automatic logic [ID_W-1:0] lowest_set(input logic [REQ_LINES-1:0] v);
    lowest_set = '0;
    for (int i = REQ_LINES - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = ID_W'(i);
    end
  endfunction

  assign w_xfer      = (r_state == BURST) && bus.out_ready;
  assign w_last_beat = w_xfer && (r_cnt == '0);

  // Pointer after the finishing grantee: only indices strictly above it keep priority.
  always_comb begin
    w_ptr_after = '0;
    for (int i = 0; i < REQ_LINES; i++) begin
      w_ptr_after[i] = (ID_W'(i) > r_gnt_id);
    end
  end

  // Arbitrating with the updated pointer on the last beat gives the no-bubble handoff.
  assign w_arb_ptr = w_last_beat ? w_ptr_after : r_ptr;
  assign w_masked  = bus.req & w_arb_ptr;
  assign w_win     = (|w_masked) ? lowest_set(w_masked) : lowest_set(bus.req);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    w_cnt_nxt    = r_cnt;

    unique case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_state_nxt  = BURST;
          w_gnt_nxt    = REQ_LINES'(1) << w_win;
          w_gnt_id_nxt = w_win;
          w_cnt_nxt    = bus.req_len[w_win*LEN_W +: LEN_W];
        end
      end
      BURST: begin
        if (w_xfer) begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - LEN_W'(1);
          end else begin
            w_ptr_nxt = w_ptr_after;
            if (|bus.req) begin
              w_gnt_nxt    = REQ_LINES'(1) << w_win;
              w_gnt_id_nxt = w_win;
              w_cnt_nxt    = bus.req_len[w_win*LEN_W +: LEN_W];
            end else begin
              w_state_nxt  = IDLE;
              w_gnt_nxt    = '0;
              w_gnt_id_nxt = '0;
              w_cnt_nxt    = '0;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_ptr    <= '1;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.out_valid = (r_state == BURST);
  assign bus.out_last  = (r_state == BURST) && (r_cnt == '0);
  assign bus.busy      = (r_state == BURST);
endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Self-checking bench for rr_burst_scheduler: a turn-taking reference model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_rr_burst_scheduler;
  localparam int N     = 4;
  localparam int LEN_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rr_burst_scheduler_if #(.REQ_LINES(N), .LEN_W(LEN_W)) bus ();

  rr_burst_scheduler #(.REQ_LINES(N), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Turn order: after requester `last` finishes, search last+1 .. N-1, then wrap to 0 .. last.
  function automatic int pick(input logic [N-1:0] r, input int last);
    int idx;
    pick = -1;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (pick < 0 && r[idx]) pick = idx;
    end
  endfunction

  function automatic int beats_of(input logic [N*LEN_W-1:0] lens, input int idx);
    logic [LEN_W-1:0] f;
    f = lens[idx*LEN_W +: LEN_W];
    beats_of = int'(f) + 1;
  endfunction

  bit m_active;
  int m_owner;
  int m_left;
  int m_last;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_owner  <= 0;
      m_left   <= 0;
      m_last   <= -1;
    end else if (!m_active) begin
      if (bus.req != '0) begin
        m_active <= 1'b1;
        m_owner  <= pick(bus.req, m_last);
        m_left   <= beats_of(bus.req_len, pick(bus.req, m_last));
      end
    end else if (bus.out_ready) begin
      if (m_left > 1) begin
        m_left <= m_left - 1;
      end else begin
        m_last <= m_owner;
        if (bus.req != '0) begin
          m_owner <= pick(bus.req, m_owner);
          m_left  <= beats_of(bus.req_len, pick(bus.req, m_owner));
        end else begin
          m_active <= 1'b0;
          m_owner  <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_gnt",    32'(bus.gnt),       m_active ? 32'(1) << m_owner : 32'd0);
    check("cyc_gnt_id", 32'(bus.gnt_id),    m_active ? 32'(m_owner) : 32'd0);
    check("cyc_valid",  32'(bus.out_valid), 32'(m_active));
    check("cyc_last",   32'(bus.out_last),  32'(m_active && m_left == 1));
    check("cyc_busy",   32'(bus.busy),      32'(m_active));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_len(input int idx, input int v);
    bus.req_len[idx*LEN_W +: LEN_W] = LEN_W'(v);
  endtask

  initial begin
    logic [N-1:0] rot [4];
    rot[0] = 4'b0010; rot[1] = 4'b0100; rot[2] = 4'b1000; rot[3] = 4'b0001;

    rst = 1'b0;
    bus.req = '1;
    bus.req_len = '0;
    bus.out_ready = 1'b1;

    // Reset held with requests pending
    repeat (3) tick();
    check("rst_gnt",   32'(bus.gnt),       32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",  32'(bus.busy),      32'd0);
    rst = 1'b1;

    // First grant one cycle after release, then fair rotation with single beats
    tick();
    check("first_gnt",  32'(bus.gnt),      32'h1);
    check("first_last", 32'(bus.out_last), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rot_gnt",  32'(bus.gnt),      32'(rot[i]));
      check("rot_last", 32'(bus.out_last), 32'd1);
    end

    // Grant index 3, go idle, then wrap-around with req=1001
    bus.req = 4'b1000;
    tick();
    check("to3_gnt", 32'(bus.gnt), 32'h8);
    bus.req = '0;
    tick();
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_gnt",  32'(bus.gnt),  32'd0);
    bus.req = 4'b1001;
    tick();
    check("wrap_gnt0", 32'(bus.gnt), 32'h1);
    tick();
    check("wrap_gnt3",    32'(bus.gnt),    32'h8);
    check("wrap_gnt_id3", 32'(bus.gnt_id), 32'd3);
    bus.req = '0;
    tick();
    check("wrap_idle", 32'(bus.gnt), 32'd0);

    // Multi-beat: requester 0 four beats, requester 2 two beats, then regrant 0
    bus.req = 4'b0101;
    set_len(0, 3);
    set_len(2, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mb0_gnt",  32'(bus.gnt),      32'h1);
      check("mb0_last", 32'(bus.out_last), 32'(i == 3));
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      check("mb2_gnt",  32'(bus.gnt),      32'h4);
      check("mb2_last", 32'(bus.out_last), 32'(i == 1));
    end
    tick();
    check("regrant0", 32'(bus.gnt), 32'h1);
    bus.req = '0;  // grantee drops mid-burst; burst must still run to completion
    repeat (3) tick();
    check("drop_gnt",  32'(bus.gnt),      32'h1);
    check("drop_last", 32'(bus.out_last), 32'd1);
    tick();
    check("drop_idle", 32'(bus.busy), 32'd0);

    // Backpressure during a three-beat burst
    set_len(1, 2);
    bus.req = 4'b0010;
    tick();
    check("bp_gnt",   32'(bus.gnt),      32'h2);
    check("bp_last0", 32'(bus.out_last), 32'd0);
    bus.req = '0;
    tick();
    check("bp_last1", 32'(bus.out_last), 32'd0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_gnt",  32'(bus.gnt),       32'h2);
      check("bp_hold_last", 32'(bus.out_last),  32'd0);
      check("bp_hold_vld",  32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_final_last", 32'(bus.out_last), 32'd1);
    tick();
    check("bp_done", 32'(bus.busy), 32'd0);

    // Reset in the middle of an eight-beat burst
    set_len(0, 7);
    bus.req = 4'b0001;
    tick();
    check("mr_gnt", 32'(bus.gnt), 32'h1);
    tick();
    check("mr_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mr_rst_gnt",  32'(bus.gnt),       32'd0);
    check("mr_rst_busy", 32'(bus.busy),      32'd0);
    check("mr_rst_vld",  32'(bus.out_valid), 32'd0);
    tick();
    rst = 1'b1;
    bus.req = 4'b0110;  // all-ones pointer favours index 1 over index 2
    tick();
    check("mr_restart_gnt", 32'(bus.gnt),    32'h2);
    check("mr_restart_id",  32'(bus.gnt_id), 32'd1);

    // Mixed traffic checked against the model only
    for (int i = 0; i < 300; i++) begin
      bus.req = N'($urandom_range(0, 15));
      for (int j = 0; j < N; j++) set_len(j, int'($urandom_range(0, 3)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    bus.req = '0;
    bus.out_ready = 1'b1;
    repeat (20) tick();
    check("drain_busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
